// File: rtl/tick_sched_pkg.sv
// tick_sched_pkg: shared FSM state encoding and parameter defaults for tick_sched
package tick_sched_pkg;
  localparam int NREQ_DEF = 4;
  localparam int DW_DEF = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2, FIN = 2'd3} state_e;
endpackage

// File: rtl/tick_sched_rr_pick.sv
// rr_pick: round-robin winner search starting just after the last owner, wrapping modulo NREQ
module rr_pick #(
  parameter int NREQ = 4,
  parameter int LW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [LW-1:0]   last,
  output logic [LW-1:0]   win,
  output logic            vld
);
  logic [LW-1:0] idx;
  // Walk from the farthest offset back to the nearest so the nearest requester wins.
  always_comb begin
    win = '0;
    idx = '0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = LW'((int'(last) + i) % NREQ);
      win = req[idx] ? idx : win;
    end
  end
  assign vld = |req;
endmodule

// File: rtl/tick_sched.sv
// tick_sched: arbitrates one shared 1 Hz countdown among NREQ requesters with abort and expiry pulse
module tick_sched import tick_sched_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  parameter int DW = DW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] dur,
  output logic               pre_clr,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic               busy
);
  localparam int LW = NREQ > 1 ? $clog2(NREQ) : 1;
  state_e state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] owner_q, owner_d, last_q, last_d, win;
  logic vld, pre_clr_q, pre_clr_d, busy_q, busy_d;
  logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic [DW-1:0] dur_a [NREQ];
  rr_pick #(.NREQ(NREQ), .LW(LW)) u_pick (.req(req), .last(last_q), .win(win), .vld(vld));
  always_comb begin
    for (int i = 0; i < NREQ; i++) dur_a[i] = dur[i*DW +: DW];
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    owner_d = owner_q;
    last_d = last_q;
    case (state_q)
      IDLE: if (vld) begin
        state_d = ARM;
        cnt_d = dur_a[win];
        owner_d = win;
      end
      ARM: if (!req[owner_q]) begin
        state_d = IDLE;
        last_d = owner_q;
      end else state_d = (cnt_q == '0) ? FIN : RUN;
      RUN: if (!req[owner_q]) begin
        state_d = IDLE;
        last_d = owner_q;
      end else if (tick) begin
        state_d = (cnt_q > DW'(1)) ? RUN : FIN;
        cnt_d = (cnt_q > DW'(1)) ? cnt_q - DW'(1) : '0;
      end
      FIN: begin
        state_d = IDLE;
        last_d = owner_q;
      end
    endcase
    // Outputs are decoded from the next state so they are registered alongside it.
    busy_d = state_d != IDLE;
    pre_clr_d = state_d == ARM;
    gnt_d = busy_d ? NREQ'(1) << owner_d : '0;
    done_d = (state_d == FIN) ? NREQ'(1) << owner_d : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      owner_q <= '0;
      last_q <= LW'(NREQ - 1);
      pre_clr_q <= 1'b0;
      gnt_q <= '0;
      done_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      owner_q <= owner_d;
      last_q <= last_d;
      pre_clr_q <= pre_clr_d;
      gnt_q <= gnt_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end
  assign pre_clr = pre_clr_q;
  assign gnt = gnt_q;
  assign done = done_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_tick_sched.sv
// tb_tick_sched: table vectors, directed corner sequences and random traffic against a transaction-level model
module tb_tick_sched;
  localparam int N = 4;
  localparam int W = 8;
  logic clk = 1'b0;
  logic reset, tick, pre_clr, busy;
  logic [N-1:0] req, gnt, done;
  logic [N*W-1:0] dur;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  tick_sched #(.NREQ(N), .DW(W)) dut (
    .clk(clk), .reset(reset), .tick(tick), .req(req), .dur(dur),
    .pre_clr(pre_clr), .gnt(gnt), .done(done), .busy(busy)
  );
  typedef struct {
    logic rst;
    logic [N-1:0] req;
    logic tick;
    logic [31:0] dur;
    logic [N-1:0] gnt;
    logic [N-1:0] done;
    logic pre;
    logic busy;
  } vec_t;
  vec_t tbl [9];
  // Model: a timer is either free or owned; an owned timer has a setup cycle, then counts ticks until it expires.
  bit m_owned = 0, m_exp = 0;
  int m_owner = 0, m_last = N - 1, m_age = 0, m_left = 0;
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic model_step();
    if (reset) begin
      m_owned = 0; m_exp = 0; m_owner = 0; m_last = N - 1;
    end else if (m_exp) begin
      m_exp = 0; m_owned = 0; m_last = m_owner;
    end else if (m_owned) begin
      if (!req[m_owner]) begin
        m_owned = 0; m_last = m_owner;
      end else if (m_age == 0) begin
        m_age = 1; m_exp = (m_left == 0);
      end else if (tick) begin
        m_left = m_left - 1; m_exp = (m_left == 0);
      end
    end else if (req != 0) begin
      for (int k = 1; k <= N; k++) begin
        if (req[(m_last + k) % N]) begin
          m_owner = (m_last + k) % N;
          break;
        end
      end
      m_owned = 1; m_age = 0; m_left = int'(dur[m_owner*W +: W]);
    end
  endtask
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask
  task automatic check_model();
    check("model_gnt", 32'(gnt), m_owned ? 32'd1 << m_owner : 32'd0);
    check("model_done", 32'(done), m_exp ? 32'd1 << m_owner : 32'd0);
    check("model_pre_clr", 32'(pre_clr), 32'(m_owned && m_age == 0));
    check("model_busy", 32'(busy), 32'(m_owned));
  endtask
  task automatic do_reset();
    reset = 1; req = '0; tick = 0; dur = '0;
    cyc();
    reset = 0;
  endtask
  initial begin
    int pc, dn, nt, t3, dc, ng, dones;
    int got [5];
    tbl[0] = '{1'b1, 4'h0, 1'b0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 4'h4, 1'b0, 32'h0, 4'h4, 4'h0, 1'b1, 1'b1};
    tbl[2] = '{1'b0, 4'h4, 1'b0, 32'h0, 4'h4, 4'h4, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 4'h0, 1'b0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 4'h1, 1'b0, 32'h1, 4'h1, 4'h0, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 4'h1, 1'b1, 32'h9, 4'h1, 4'h0, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 4'h1, 1'b0, 32'h9, 4'h1, 4'h0, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 4'h1, 1'b1, 32'h9, 4'h1, 4'h1, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 4'h0, 1'b0, 32'h9, 4'h0, 4'h0, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      reset = tbl[i].rst; req = tbl[i].req; tick = tbl[i].tick; dur = tbl[i].dur;
      cyc();
      check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      check($sformatf("vec%0d_done", i), 32'(done), 32'(tbl[i].done));
      check($sformatf("vec%0d_pre_clr", i), 32'(pre_clr), 32'(tbl[i].pre));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
    end
    // Single requester, dur 3, tick every 10 cycles.
    do_reset();
    dur[0 +: W] = 8'd3; req = 4'b0001;
    pc = 0; dn = 0; nt = 0; t3 = -1; dc = -1;
    for (int c = 0; c < 80 && dn == 0; c++) begin
      tick = (c % 10 == 9);
      if (tick) begin
        nt++;
        if (nt == 3) t3 = c;
      end
      cyc();
      check_model();
      if (busy) check("single_gnt", 32'(gnt), 32'h1);
      if (pre_clr) pc++;
      if (done != 0) begin
        dn++; dc = c;
      end
    end
    check("single_pre_clr_count", pc, 1);
    check("single_done_count", dn, 1);
    check("single_done_after_third_tick", dc, t3);
    req = '0; tick = 0;
    cyc();
    // All four requesting, dur 1 each: rotate 0,1,2,3,0.
    do_reset();
    dur = {4{8'd1}}; req = 4'b1111;
    ng = 0; dones = 0;
    for (int c = 0; c < 300 && dones < 5; c++) begin
      tick = (c % 3 == 2);
      cyc();
      check_model();
      if (pre_clr && ng < 5) begin
        got[ng] = $clog2(gnt); ng++;
      end
      if (done != 0) dones++;
    end
    check("rr_grants", ng, 5);
    check("rr_dones", dones, 5);
    for (int i = 0; i < 5; i++) check($sformatf("rr_order%0d", i), got[i], i % 4);
    req = '0; tick = 0;
    cyc();
    // Abort of owner 1 coincident with a tick.
    do_reset();
    dur[1*W +: W] = 8'd5; req = 4'b0010;
    cyc(); check_model();
    cyc(); check_model();
    for (int k = 0; k < 2; k++) begin
      tick = 1; cyc(); check_model();
      tick = 0; cyc(); check_model();
    end
    req = '0; tick = 1;
    cyc();
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_gnt", 32'(gnt), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    tick = 0; req = 4'b1111;
    cyc();
    check("abort_next_gnt", 32'(gnt), 32'h4);
    check("abort_next_pre_clr", 32'(pre_clr), 32'h1);
    req = '0;
    cyc(); cyc();
    // Reset in the middle of a countdown.
    do_reset();
    dur[0 +: W] = 8'd6; req = 4'b0001;
    cyc(); cyc();
    for (int k = 0; k < 2; k++) begin
      tick = 1; cyc(); check_model();
      tick = 0; cyc(); check_model();
    end
    reset = 1;
    cyc();
    check("rst_mid_gnt", 32'(gnt), 32'h0);
    check("rst_mid_done", 32'(done), 32'h0);
    check("rst_mid_busy_pre", 32'({busy, pre_clr}), 32'h0);
    reset = 0; req = 4'b1000;
    cyc();
    check("rst_after_gnt", 32'(gnt), 32'h8);
    check("rst_after_pre_clr", 32'(pre_clr), 32'h1);
    req = '0;
    cyc(); cyc();
    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom % 8 == 0) req = N'($urandom);
      if (c % 16 == 0)
        for (int i = 0; i < N; i++) dur[i*W +: W] = W'($urandom_range(0, 4));
      tick = ($urandom % 4 == 0);
      reset = ($urandom % 500 == 0);
      cyc();
      check_model();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tick_sched.md
TICK_SCHED -- requirements
Module: tick_sched

Interface
REQ-001 Parameter: NREQ, default 4, number of timer requesters.
REQ-002 Parameter: DW, default 8, duration width in seconds.
REQ-003 Port: clk  input  1  system clock; the single clock for all state.
REQ-004 Port: reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 Port: tick  input  1  one-cycle 1 Hz strobe from the prescaler chain.
REQ-006 Port: req  input  NREQ  level request per requester; held until done or until withdrawn.
REQ-007 Port: dur  input  NREQ*DW  per-requester duration in ticks; slice i = dur[i*DW +: DW].
REQ-008 Port: pre_clr  output  1  one-cycle clear to the prescaler chain, issued at grant.
REQ-009 Port: gnt  output  NREQ  one-hot owner of the shared countdown; all zero when no owner.
REQ-010 Port: done  output  NREQ  one-cycle one-hot expiry pulse to the owner.
REQ-011 Port: busy  output  1  high in every state except IDLE.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, ARM, RUN, FIN.
REQ-013 IDLE: if any req bit is high, the FSM SHALL select winner w by round-robin, searching from last+1 upward with wrap modulo NREQ.
REQ-014 IDLE->ARM on selection: latch cnt <= dur slice w, set owner <= w, and assert pre_clr in the ARM cycle only.
REQ-015 ARM: tick SHALL be ignored; next state is FIN if cnt==0, otherwise RUN.
REQ-016 RUN: on tick with cnt>1, cnt SHALL decrement by 1; on tick with cnt==1, next state is FIN and cnt becomes 0.
REQ-017 FIN: done[owner] SHALL be high for exactly this one cycle, last <= owner, then the FSM SHALL return to IDLE.
REQ-018 gnt[owner] SHALL be high in ARM, RUN and FIN, and gnt SHALL be zero in IDLE.
REQ-019 Abort: if req[owner] falls in ARM or RUN, the FSM SHALL go to IDLE next cycle with no done pulse, and last <= owner.
REQ-020 Abort SHALL take priority over a tick arriving in the same cycle.
REQ-021 A requester still holding req after its done pulse SHALL be re-arbitrated normally; it has no priority.
REQ-022 Requests and dur SHALL be sampled only in IDLE; changes to dur after grant SHALL have no effect.
REQ-023 Latency: grant to done SHALL be dur ticks after ARM; dur==0 SHALL give done two cycles after IDLE selection.
REQ-024 Counter arithmetic SHALL be unsigned DW bits and SHALL never wrap below 0.

Reset
REQ-025 On reset, the block SHALL clear to: state IDLE, cnt 0, owner 0, last NREQ-1 (so requester 0 wins first), and gnt, done, pre_clr, busy all 0.
REQ-026 Reset SHALL override every other input in the same cycle, including mid-RUN; no done pulse SHALL be emitted for an interrupted countdown.

Structure
REQ-027 A shared package SHALL hold the state encoding constants (IDLE=0, ARM=1, RUN=2, FIN=3) and the NREQ and DW defaults.
REQ-028 The round-robin selector SHALL be one combinational sub-module, rr_pick, with inputs req and last and outputs the winner index and a valid flag.
REQ-029 All other logic SHALL be in tick_sched.

Verification
REQ-030 Reset, then req=0001 with dur0=3 and ticks every 10 cycles -> pre_clr pulses once; done[0] fires on the cycle after the 3rd tick; gnt=0001 throughout.
REQ-031 req=1111 held with all dur=1 -> grants in order 0,1,2,3,0 with exactly one done per grant.
REQ-032 dur2=0 and only req[2] high -> sequence ARM then FIN; done[2] two cycles after selection; no tick required.
REQ-033 Owner 1 with dur=5; drop req[1] after 2 ticks, coincident with a tick -> IDLE next cycle, no done, and the next arbitration starts from index 2.
REQ-034 Assert reset mid-RUN with cnt=4 -> all outputs 0 the next cycle, no done; after release, req=1000 is granted normally.
REQ-035 Tick asserted in the ARM cycle -> cnt unchanged; the full dur count still elapses.
